stride: RTL and testbench

- Bit-decimation block: takes a LEN-bit word and outputs every STRIDE-th bit, packed into a LEN/STRIDE-bit word.
- A runtime phase input selects which bit within each STRIDE-bit group is kept.
- Output is registered with a valid flag, so it sits in clocked datapaths between producer and consumer stages.

---
 rtl/stride.sv | 99 +++++++++
 tb/tb_stride.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/stride.sv
// stride: bit-decimation block. Keeps one bit out of every STRIDE-bit group
// of a LEN-bit word and packs the kept bits, LSB group first, into a
// LEN/STRIDE-bit registered output with a one-cycle valid strobe.
// The runtime phase selects which bit of each group is kept; phase codes
// >= STRIDE select bit 0, so unused codes never produce X.
// Optional macro STRIDE_PARITY_EN adds a registered parity output
// (strided_par) covering the selected bits.

// Per-group selector: picks bit p out of one STRIDE-bit group.
module stride_lane #(
  parameter int STRIDE = 2,
  parameter int PW     = 1
) (
  input  logic [STRIDE-1:0] grp,
  input  logic [PW-1:0]     p,
  output logic              sel
);

  // One-hot style mux; p is already clamped into 0..STRIDE-1 by the caller.
  always_comb begin
    sel = 1'b0;
    for (int j = 0; j < STRIDE; j++) begin
      if (p == PW'(j)) sel = grp[j];
    end
  end

endmodule

module stride #(
  parameter int  LEN    = 8,
  parameter int  STRIDE = 2,
  localparam int NG     = (STRIDE >= 1) ? LEN / STRIDE : 1,
  localparam int PW     = (STRIDE > 1) ? $clog2(STRIDE) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [PW-1:0] phase,
  input  logic [LEN-1:0] in,
  output logic [NG-1:0] strided_out,
`ifdef STRIDE_PARITY_EN
  output logic          strided_par,
`endif
  output logic          out_valid
);

  // Reject geometries that cannot be split into whole groups.
  generate
    if (LEN < 1) begin : g_bad_len
      $error("stride: LEN must be >= 1");
    end
    if (STRIDE < 1) begin : g_bad_stride
      $error("stride: STRIDE must be >= 1");
    end else if (LEN % STRIDE != 0) begin : g_bad_div
      $error("stride: STRIDE must divide LEN exactly");
    end
  endgenerate

  logic [PW-1:0] p_eff;
  logic [NG-1:0] sel;

  // Out-of-range phase codes fall back to bit 0 of each group.
  always_comb begin
    p_eff = '0;
    if (int'(phase) < STRIDE) p_eff = phase;
  end

  // One selector per output bit; group i spans in[i*STRIDE +: STRIDE].
  for (genvar i = 0; i < NG; i++) begin : g_lane
    stride_lane #(
      .STRIDE(STRIDE),
      .PW    (PW)
    ) u_lane (
      .grp(in[i*STRIDE +: STRIDE]),
      .p  (p_eff),
      .sel(sel[i])
    );
  end

  // Output register: reset wins, otherwise load on in_valid and hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      strided_out <= '0;
      out_valid   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) strided_out <= sel;
    end
  end

`ifdef STRIDE_PARITY_EN
  // Parity of the selected bits, updated alongside strided_out.
  always_ff @(posedge clk) begin
    if (rst)           strided_par <= 1'b0;
    else if (in_valid) strided_par <= ^sel;
  end
`endif

endmodule

// File: tb/tb_stride.sv
// Scoreboard bench for stride. Three instances share one stimulus stream:
//   A: LEN=8 STRIDE=2, B: LEN=8 STRIDE=4, C: LEN=6 STRIDE=3 (C has a
//   representable out-of-range phase code, 3).
// The driver pushes the expected response (stamped with the cycle it must
// appear on) into a per-instance queue; a negedge monitor pops and compares.
module tb_stride;

  typedef struct {
    int         cyc;
    logic       v;
    logic [7:0] val;
    logic       par;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_w = '0;
  logic       ph_a = '0;
  logic [1:0] ph_b = '0;
  logic [1:0] ph_c = '0;

  logic [3:0] so_a;
  logic [1:0] so_b;
  logic [1:0] so_c;
  logic       ov_a, ov_b, ov_c;
  logic       par_a, par_b, par_c;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  ent_t       q [3][$];
  logic [7:0] last_v [3];
  logic       last_p [3];
  bit         started [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stride #(.LEN(8), .STRIDE(2)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .phase(ph_a), .in(in_w),
    .strided_out(so_a),
`ifdef STRIDE_PARITY_EN
    .strided_par(par_a),
`endif
    .out_valid(ov_a));

  stride #(.LEN(8), .STRIDE(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .phase(ph_b), .in(in_w),
    .strided_out(so_b),
`ifdef STRIDE_PARITY_EN
    .strided_par(par_b),
`endif
    .out_valid(ov_b));

  stride #(.LEN(6), .STRIDE(3)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .phase(ph_c), .in(in_w[5:0]),
    .strided_out(so_c),
`ifdef STRIDE_PARITY_EN
    .strided_par(par_c),
`endif
    .out_valid(ov_c));

`ifndef STRIDE_PARITY_EN
  assign par_a = 1'b0;
  assign par_b = 1'b0;
  assign par_c = 1'b0;
`endif

  // Reference: output bit i is word bit i*s + p, p = phase if in range else 0.
  function automatic logic [7:0] ref_sel(logic [7:0] w, int len, int s, int ph);
    int p;
    logic [7:0] r;
    p = (ph < s) ? ph : 0;
    r = '0;
    for (int i = 0; i < len / s; i++) r[i] = w[i * s + p];
    return r;
  endfunction

  task automatic chk(string nm, int k, logic [7:0] got, logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", nm, k, cyc, got, exp);
    end
  endtask

  task automatic push(int k, logic r, logic v, logic [7:0] w, int len, int s, int ph);
    ent_t e;
    e.cyc = cyc + 1;
    if (r) begin
      e.v = 1'b0; e.val = '0; e.par = 1'b0;
    end else begin
      e.v = 1'b1; e.val = ref_sel(w, len, s, ph); e.par = ^e.val;
    end
    if (r || v) q[k].push_back(e);
  endtask

  // Drive one cycle of stimulus and record what each instance owes us.
  task automatic step(logic r, logic v, logic [7:0] w, logic pa, logic [1:0] pb,
                      logic [1:0] pc);
    rst = r; in_valid = v; in_w = w; ph_a = pa; ph_b = pb; ph_c = pc;
    push(0, r, v, w, 8, 2, int'(pa));
    push(1, r, v, w, 8, 4, int'(pb));
    push(2, r, v, {2'b00, w[5:0]}, 6, 3, int'(pc));
    @(posedge clk);
    #1;
  endtask

  task automatic mon(int k, logic ov, logic [7:0] so, logic sp);
    ent_t e;
    if (q[k].size() > 0 && q[k][0].cyc == cyc) begin
      e = q[k].pop_front();
      chk("out_valid", k, {7'd0, ov}, {7'd0, e.v});
      chk("strided_out", k, so, e.val);
`ifdef STRIDE_PARITY_EN
      chk("strided_par", k, {7'd0, sp}, {7'd0, e.par});
`endif
      last_v[k] = e.val;
      last_p[k] = e.par;
      started[k] = 1'b1;
    end else if (started[k]) begin
      chk("idle_valid", k, {7'd0, ov}, 8'd0);
      chk("hold_out", k, so, last_v[k]);
`ifdef STRIDE_PARITY_EN
      chk("hold_par", k, {7'd0, sp}, {7'd0, last_p[k]});
`endif
    end
  endtask

  // Monitor: outputs are compared on the falling edge, away from updates.
  always @(negedge clk) begin
    mon(0, ov_a, {4'd0, so_a}, par_a);
    mon(1, ov_b, {6'd0, so_b}, par_b);
    mon(2, ov_c, {6'd0, so_c}, par_c);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      last_v[k] = '0; last_p[k] = 1'b0; started[k] = 1'b0;
    end
    // Reset with a live word that must be discarded.
    step(1, 1, 8'hFF, 0, 0, 0);
    step(1, 1, 8'hFF, 0, 0, 0);
    // STRIDE=2, phase 0, back-to-back.
    step(0, 1, 8'b1010_0000, 0, 0, 0);
    step(0, 1, 8'b0101_0101, 0, 0, 0);
    step(0, 1, 8'b1010_1010, 0, 0, 0);
    // STRIDE=2, phase 1.
    step(0, 1, 8'b1010_1010, 1, 1, 1);
    step(0, 1, 8'b1010_0000, 1, 1, 1);
    // Hold after a 4'b1111 result.
    step(0, 1, 8'b1010_1010, 1, 1, 1);
    step(0, 0, 8'h00, 0, 0, 0);
    step(0, 0, 8'h00, 0, 0, 0);
    step(0, 0, 8'h00, 0, 0, 0);
    // STRIDE=4 phase 3; STRIDE=3 with out-of-range phase 3.
    step(0, 1, 8'b1000_1000, 0, 3, 3);
    step(0, 1, 8'b0001_0000, 0, 0, 3);
    step(0, 1, 8'b0000_1001, 0, 2, 3);
    // Parity patterns.
    step(0, 1, 8'b0000_0101, 0, 0, 0);
    step(0, 1, 8'b0000_0001, 0, 0, 0);
    // Reset in the middle of traffic, then random traffic.
    step(1, 1, 8'h5A, 1, 2, 2);
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 9) < 7),
           8'($urandom), 1'($urandom), 2'($urandom), 2'($urandom));
    end
    step(0, 0, 8'h00, 0, 0, 0);
    step(0, 0, 8'h00, 0, 0, 0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("drain", k, 8'(q[k].size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
